inst_encoder: RTL and testbench
===============================

# inst_encoder

Pipelined RV32IM + Zicsr instruction encoder: the inverse of the core's instruction decoder. It accepts decoded instruction fields over a valid/ready handshake and emits the 32-bit instruction word, a flag for illegal or out-of-range fields, and a sequential instruction-memory word address. It sits between the self-test/program-loader sequencer and the instruction-memory write port, and generates decoder and core stimulus in-system.

## Interface
- `ADDR_W`, 10: width of the instruction-memory word address; the counter wraps modulo 2^ADDR_W.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid` / `in_ready`  in / out  1 / 1  input handshake.
- `in_kind`  in  4  instruction class: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, IMM, REG, MEXT, CSR, SYSTEM (codes 0–11); codes 12–15 are reserved.
- `in_funct3`  in  3  funct3 field; for SYSTEM kind it must be 0.
- `in_alt`  in  1  selects SUB/SRA (funct7 = 0x20) for REG, and SRAI for IMM.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  32  signed immediate, byte offset for branch and jump; for CSR-immediate forms it carries the zimm value.
- `in_csr_addr`  in  12  CSR address.
- `in_sys_sel`  in  2  0 = ECALL, 1 = EBREAK, 2 = MRET, 3 = illegal.
- `addr_clr`  in  1  synchronous clear of the address counter.
- `out_valid` / `out_ready`  out / in  1 / 1  output handshake.
- `out_inst`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  word address assigned to `out_inst`.
- `out_err`  out  1  the beat was illegal; `out_inst` is forced to NOP.
- `addr_wrap`  out  1  one-cycle pulse when the counter wraps from the maximum address to 0.

## Operation
- The encoder is a single output register stage. `in_ready = !out_valid || out_ready`.
- An input beat is accepted when `in_valid && in_ready`. On acceptance:
  - the word is encoded combinationally;
  - it is captured into `out_inst`/`out_addr`/`out_err`;
  - `out_valid` is set to 1.
- `out_valid` clears when `out_ready` is high and no new beat is accepted in the same cycle.
- Formats:
  - U: LUI, AUIPC.
  - J: JAL.
  - I: JALR, LOAD, IMM, CSR.
  - S: STORE.
  - B: BRANCH.
  - R: REG, MEXT; MEXT uses funct7 = 0000001.
- CSR: `inst[31:20] = in_csr_addr`. When funct3[2] = 1, `in_imm[4:0]` goes in `inst[19:15]`; otherwise `in_rs1` does.
- SYSTEM emits fixed words: ECALL 0x00000073, EBREAK 0x00100073, MRET 0x30200073.
- Error conditions (`out_err` = 1, `out_inst` = 0x00000013):
  - reserved kind, or `in_sys_sel` = 3;
  - I or S immediate outside [-2048, 2047];
  - B immediate outside [-4096, 4094] or odd;
  - J immediate outside [-2^20, 2^20 - 2] or odd;
  - U immediate with nonzero bits [11:0];
  - shift immediates (IMM with funct3 001/101) outside 0..31;
  - zimm outside 0..31;
  - SLLI with `in_alt` = 1;
  - illegal funct3: BRANCH 010/011; LOAD 011/110/111; STORE > 010; JALR ≠ 000; CSR 000/100; SYSTEM ≠ 000.
- Address counter:
  - An accepted legal beat takes the current count as its `out_addr`, then the count increments.
  - An accepted error beat takes the current count but does not increment it.
  - When the count is at 2^ADDR_W - 1, incrementing sets it to 0 and pulses `addr_wrap` in the following cycle.
- `addr_clr` together with an acceptance: the beat keeps its pre-clear address, the counter becomes 0, and no `addr_wrap` pulse is generated.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`. Throughput: 1 beat per cycle under continuous `out_ready`.
- Under backpressure (`out_valid && !out_ready`), the output is held stable and `in_ready` = 0. No beat is lost or duplicated.
- Reset values: `out_valid` = 0, `out_inst` = 0, `out_addr` = 0, `out_err` = 0, `addr_wrap` = 0, counter = 0; `in_ready` = 1 after reset.
- Reset asserted mid-operation discards any held beat on that edge.
- `in_*` fields are ignored when `in_valid` = 0.

## Structure
- Shared package `inst_enc_pkg` holds:
  - the `in_kind` codes;
  - RV opcode constants (0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011);
  - the NOP constant 0x00000013 and the fixed system words.
  - The core decoder's opcode definitions move into this package.
- Sub-module `inst_enc_comb`: purely combinational fields-to-{word, err}. The top level holds the register stage, handshake and address counter.

## Test plan
- ADDI x1,x0,5 (IMM, f3 = 0, imm = 5) after reset → `out_inst` 0x00500093, `out_addr` 0, `out_err` 0, one cycle after acceptance.
- SUB x3,x1,x2 (REG, `in_alt` = 1), then BEQ x1,x2,+8, back-to-back → 0x402081B3 at address 0, 0x00208463 at address 1.
- CSRRWI x5,0x300,3, then MRET → 0x3001D2F3, then 0x30200073.
- ADDI with imm 2048 → `out_err` 1, `out_inst` 0x00000013; the next legal beat reuses the same address.
- `out_ready` held low for 3 cycles with `in_valid` high → output stable, `in_ready` 0, no loss; every beat is delivered once after release.
- `ADDR_W` = 2: five legal beats → addresses 0, 1, 2, 3, 0 and one `addr_wrap` pulse. `addr_clr` on the 3rd beat's acceptance cycle → that beat gets address 2 and the next beat gets 0.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared RV32IM/Zicsr encoding constants: instruction kinds, major opcodes and fixed words.
// The core decoder imports its opcode definitions from here as well.
package inst_enc_pkg;

  typedef enum logic [3:0] {
    KIND_LUI    = 4'd0,
    KIND_AUIPC  = 4'd1,
    KIND_JAL    = 4'd2,
    KIND_JALR   = 4'd3,
    KIND_BRANCH = 4'd4,
    KIND_LOAD   = 4'd5,
    KIND_STORE  = 4'd6,
    KIND_IMM    = 4'd7,
    KIND_REG    = 4'd8,
    KIND_MEXT   = 4'd9,
    KIND_CSR    = 4'd10,
    KIND_SYSTEM = 4'd11
  } kind_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // True when every bit above msb is a copy of bit msb, i.e. v fits as a signed (msb+1)-bit value.
  function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i > int'(msb)) && (v[i] != v[msb])) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/inst_enc_comb.sv
// Purely combinational fields-to-instruction encoder with legality check.
// Illegal or out-of-range fields yield err = 1 and a NOP word.
module inst_enc_comb
  import inst_enc_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  sys_sel,
  output logic [31:0] inst,
  output logic        err
);

  logic [31:0] word_s;
  logic        bad_s;
  logic        i_ok_s;
  logic        b_ok_s;
  logic        j_ok_s;
  logic        small_s;

  // Encode each instruction class and flag illegal field combinations.
  always_comb begin
    word_s  = INST_NOP;
    bad_s   = 1'b0;
    i_ok_s  = fits_signed(imm, 5'd11);
    b_ok_s  = fits_signed(imm, 5'd12) && (imm[0] == 1'b0);
    j_ok_s  = fits_signed(imm, 5'd20) && (imm[0] == 1'b0);
    small_s = (imm[31:5] == 27'd0);
    case (kind_e'(kind))
      KIND_LUI: begin
        bad_s  = (imm[11:0] != 12'd0);
        word_s = {imm[31:12], rd, OPC_LUI};
      end
      KIND_AUIPC: begin
        bad_s  = (imm[11:0] != 12'd0);
        word_s = {imm[31:12], rd, OPC_AUIPC};
      end
      KIND_JAL: begin
        bad_s  = !j_ok_s;
        word_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      KIND_JALR: begin
        bad_s  = !i_ok_s || (funct3 != 3'b000);
        word_s = {imm[11:0], rs1, funct3, rd, OPC_JALR};
      end
      KIND_BRANCH: begin
        bad_s  = !b_ok_s || (funct3[2:1] == 2'b01);
        word_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      end
      KIND_LOAD: begin
        bad_s  = !i_ok_s || (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        word_s = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      end
      KIND_STORE: begin
        bad_s  = !i_ok_s || (funct3 > 3'b010);
        word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      end
      KIND_IMM: begin
        // Shifts carry a 5-bit shamt with funct7 in the upper immediate bits.
        if (funct3[1:0] == 2'b01) begin
          bad_s  = !small_s || ((funct3[2] == 1'b0) && alt);
          word_s = {(funct3[2] && alt) ? FUNCT7_ALT : FUNCT7_BASE, imm[4:0], rs1, funct3, rd,
                    OPC_OP_IMM};
        end else begin
          bad_s  = !i_ok_s;
          word_s = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
        end
      end
      KIND_REG: begin
        bad_s  = 1'b0;
        word_s = {alt ? FUNCT7_ALT : FUNCT7_BASE, rs2, rs1, funct3, rd, OPC_OP};
      end
      KIND_MEXT: begin
        bad_s  = 1'b0;
        word_s = {FUNCT7_MEXT, rs2, rs1, funct3, rd, OPC_OP};
      end
      KIND_CSR: begin
        bad_s  = (funct3[1:0] == 2'b00) || (funct3[2] && !small_s);
        word_s = {csr_addr, funct3[2] ? imm[4:0] : rs1, funct3, rd, OPC_SYSTEM};
      end
      KIND_SYSTEM: begin
        case (sys_sel)
          2'd0: begin
            bad_s  = (funct3 != 3'b000);
            word_s = INST_ECALL;
          end
          2'd1: begin
            bad_s  = (funct3 != 3'b000);
            word_s = INST_EBREAK;
          end
          2'd2: begin
            bad_s  = (funct3 != 3'b000);
            word_s = INST_MRET;
          end
          default: begin
            bad_s  = 1'b1;
            word_s = INST_NOP;
          end
        endcase
      end
      default: begin
        bad_s  = 1'b1;
        word_s = INST_NOP;
      end
    endcase
  end

  assign inst = bad_s ? INST_NOP : word_s;
  assign err  = bad_s;

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder top: one registered output stage with valid/ready handshake
// and a word-address counter that advances only on legal beats.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic [11:0]       in_csr_addr,
  input  logic [1:0]        in_sys_sel,
  input  logic              addr_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              addr_wrap
);

  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [31:0]       enc_inst_s;
  logic              enc_err_s;
  logic              accept_s;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_err_q,   out_err_d;
  logic              addr_wrap_q, addr_wrap_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;

  inst_enc_comb u_comb (
    .kind     (in_kind),
    .funct3   (in_funct3),
    .alt      (in_alt),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .csr_addr (in_csr_addr),
    .sys_sel  (in_sys_sel),
    .inst     (enc_inst_s),
    .err      (enc_err_s)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // Next-state for the output stage and the address counter.
  always_comb begin
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    addr_wrap_d = 1'b0;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst_s;
      out_addr_d  = cnt_q;
      out_err_d   = enc_err_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    // A clear overrides the increment and suppresses the wrap pulse.
    if (addr_clr) begin
      cnt_d = {ADDR_W{1'b0}};
    end else if (accept_s && !enc_err_s) begin
      cnt_d       = cnt_q + CNT_ONE;
      addr_wrap_d = (cnt_q == CNT_MAX);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'd0;
      out_addr_q  <= {ADDR_W{1'b0}};
      out_err_q   <= 1'b0;
      addr_wrap_q <= 1'b0;
      cnt_q       <= {ADDR_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      addr_wrap_q <= addr_wrap_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign addr_wrap = addr_wrap_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against a field-arithmetic reference model and a beat queue.
module tb_inst_encoder;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_kind;
  logic [2:0]    in_funct3;
  logic          in_alt;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic [11:0]   in_csr_addr;
  logic [1:0]    in_sys_sel;
  logic          addr_clr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic          addr_wrap;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_csr_addr(in_csr_addr),
    .in_sys_sel(in_sys_sel), .addr_clr(addr_clr), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .addr_wrap(addr_wrap)
  );

  typedef struct packed {
    logic [31:0]   inst;
    logic [AW-1:0] addr;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cnt_m = 0;
  logic  wrap_m = 1'b0;
  int    wraps_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder written from the ISA field rules using integer arithmetic.
  function automatic void ref_enc(input int kind, input int f3, input int alt, input int rd,
                                  input int rs1, input int rs2, input int imm, input int csr,
                                  input int sys, output logic [31:0] w, output logic e);
    int shift;
    shift = (f3 == 1 || f3 == 5);
    e = 1'b0;
    w = 32'h13;
    case (kind)
      0, 1: begin
        e = (imm & 'hFFF) != 0;
        w = (imm & 'hFFFFF000) | (rd << 7) | (kind == 0 ? 'h37 : 'h17);
      end
      2: begin
        e = imm < -(1 << 20) || imm > (1 << 20) - 2 || (imm & 1) != 0;
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20)
          | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
      end
      3, 5, 7: begin
        e = imm < -2048 || imm > 2047;
        if (kind == 3) e = e || f3 != 0;
        if (kind == 5) e = e || f3 == 3 || f3 == 6 || f3 == 7;
        if (kind == 7 && shift) e = imm < 0 || imm > 31 || (f3 == 1 && alt != 0);
        w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
          | (kind == 3 ? 'h67 : kind == 5 ? 'h03 : 'h13);
        if (kind == 7 && shift && f3 == 5 && alt != 0) w = w | 32'h4000_0000;
      end
      4: begin
        e = f3 == 2 || f3 == 3 || imm < -4096 || imm > 4094 || (imm & 1) != 0;
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
      end
      6: begin
        e = f3 > 2 || imm < -2048 || imm > 2047;
        w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 'h1F) << 7) | 'h23;
      end
      8, 9: begin
        w = ((kind == 9) ? (1 << 25) : (alt != 0 ? (32 << 25) : 0))
          | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      end
      10: begin
        e = f3 == 0 || f3 == 4 || (f3 >= 4 && (imm < 0 || imm > 31));
        w = (csr << 20) | ((f3 >= 4 ? (imm & 31) : rs1) << 15) | (f3 << 12) | (rd << 7) | 'h73;
      end
      11: begin
        e = f3 != 0 || sys == 3;
        w = (sys == 0) ? 'h73 : (sys == 1) ? 'h0010_0073 : 'h3020_0073;
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h13;
  endfunction

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_inst", out_inst, exp_q[0].inst);
      chk("out_addr", 32'(out_addr), 32'(exp_q[0].addr));
      chk("out_err", 32'(out_err), 32'(exp_q[0].err));
    end
    chk("addr_wrap", 32'(addr_wrap), 32'(wrap_m));
    if (addr_wrap) wraps_seen++;
  endtask

  // Called with stimulus applied at a negedge; advances one clock and checks the result.
  task automatic tick();
    logic [31:0]   w;
    logic          e;
    logic          rdy;
    logic [AW-1:0] a;
    #1;
    rdy = (exp_q.size() == 0) || out_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    wrap_m = 1'b0;
    if (in_valid && rdy) begin
      ref_enc(in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, in_csr_addr,
              in_sys_sel, w, e);
      a = cnt_m[AW-1:0];
      exp_q.push_back('{inst: w, addr: a, err: e});
      if (addr_clr) cnt_m = 0;
      else if (!e) begin
        if (cnt_m == (1 << AW) - 1) begin
          cnt_m  = 0;
          wrap_m = 1'b1;
        end else cnt_m++;
      end
    end else if (addr_clr) cnt_m = 0;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_beat(input int kind, input int f3, input int alt, input int rd,
                          input int rs1, input int rs2, input int imm, input int csr,
                          input int sys);
    in_kind = 4'(kind); in_funct3 = 3'(f3); in_alt = 1'(alt); in_rd = 5'(rd);
    in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm; in_csr_addr = 12'(csr);
    in_sys_sel = 2'(sys); in_valid = 1'b1;
  endtask

  function automatic int rand_imm();
    int bl[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                   (1 << 20) - 2, 1 << 20, -(1 << 20), 31, 32, -1};
    case ($urandom_range(0, 5))
      0: return int'($urandom_range(0, 6000)) - 3000;
      1: return int'($urandom_range(0, 40));
      2: return bl[$urandom_range(0, 13)];
      3: return int'($urandom);
      4: return int'($urandom & 32'hFFFF_F000);
      default: return (int'($urandom_range(0, 2200000)) - 1100000) & ~1;
    endcase
  endfunction

  task automatic idle_clr();
    in_valid = 1'b0; addr_clr = 1'b1; out_ready = 1'b1;
    tick();
    addr_clr = 1'b0;
  endtask

  initial begin
    int exp_a[5];
    int kind;
    rst_n = 1'b0; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b1;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_wrap", 32'(addr_wrap), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    set_beat(7, 0, 0, 1, 0, 0, 5, 0, 0);
    tick();
    chk("addi_inst", out_inst, 32'h0050_0093);
    chk("addi_addr", 32'(out_addr), 32'd0);
    chk("addi_err", 32'(out_err), 32'd0);

    idle_clr();
    set_beat(8, 0, 1, 3, 1, 2, 0, 0, 0);
    tick();
    chk("sub_inst", out_inst, 32'h4020_81B3);
    chk("sub_addr", 32'(out_addr), 32'd0);
    set_beat(4, 0, 0, 0, 1, 2, 8, 0, 0);
    tick();
    chk("beq_inst", out_inst, 32'h0020_8463);
    chk("beq_addr", 32'(out_addr), 32'd1);

    set_beat(10, 5, 0, 5, 0, 0, 3, 'h300, 0);
    tick();
    chk("csrrwi_inst", out_inst, 32'h3001_D2F3);
    set_beat(11, 0, 0, 0, 0, 0, 0, 0, 2);
    tick();
    chk("mret_inst", out_inst, 32'h3020_0073);
    chk("mret_wrap", 32'(addr_wrap), 32'd1);

    set_beat(7, 0, 0, 1, 0, 0, 2048, 0, 0);
    tick();
    chk("bigimm_err", 32'(out_err), 32'd1);
    chk("bigimm_inst", out_inst, 32'h0000_0013);
    chk("bigimm_addr", 32'(out_addr), 32'd0);
    set_beat(7, 0, 0, 1, 0, 0, 7, 0, 0);
    tick();
    chk("reuse_addr", 32'(out_addr), 32'd0);
    chk("reuse_err", 32'(out_err), 32'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(7, 0, 0, i + 2, 0, 0, 100 + i, 0, 0);
      tick();
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_inst", out_inst, 32'h0070_0093);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_inst", out_inst, 32'h0660_0213);

    idle_clr();
    wraps_seen = 0;
    exp_a = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      set_beat(7, 0, 0, i, 0, 0, i, 0, 0);
      tick();
      chk("wrap_seq_addr", 32'(out_addr), 32'(exp_a[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_pulses", 32'(wraps_seen), 32'd1);

    idle_clr();
    wraps_seen = 0;
    exp_a = '{0, 1, 2, 0, 1};
    for (int i = 0; i < 5; i++) begin
      set_beat(7, 0, 0, i, 0, 0, i, 0, 0);
      addr_clr = (i == 2);
      tick();
      chk("clr_seq_addr", 32'(out_addr), 32'(exp_a[i]));
    end
    addr_clr = 1'b0; in_valid = 1'b0;
    tick();
    chk("clr_pulses", 32'(wraps_seen), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete(); cnt_m = 0; wrap_m = 1'b0;
        chk("midrst_inst", out_inst, 32'd0);
        check_outputs();
      end
      kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
      set_beat(kind, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 31), rand_imm(),
               $urandom_range(0, 4095), $urandom_range(0, 3));
      if (kind == 11 && $urandom_range(0, 1) == 1) in_funct3 = 3'd0;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      addr_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
